// File: rtl/sort_pkg.sv
// Shared constants, FSM state type and LFSR step function for the sort data loader.
//   DATA_W/ADDR_W : memory word / address widths (DATA_W is tied to the 32-bit LFSR)
//   LFSR_TAPS     : Galois feedback mask, x^32+x^22+x^2+x+1
//   DEFAULT_SEED  : LFSR value after reset and in place of a zero seed
package sort_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 10;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        FILL,
        HANDOFF
    } state_e;

    // One Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/sort_data_loader_if.sv
// Sort memory write-port bundle.
//   we   : write enable
//   addr : write address (ADDR_W bits)
//   din  : write data (DATA_W bits)
// master drives the port (the loader), slave is the memory side.
interface sort_data_loader_if;
    import sort_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;

    modport master (output we, addr, din);
    modport slave  (input  we, addr, din);

endinterface

// File: rtl/sort_lfsr.sv
// 32-bit Galois LFSR used as the fill data source.
//   clk, rstn : clock, synchronous active-low reset (resets to DEFAULT_SEED)
//   load_seed : load seed (zero is replaced by DEFAULT_SEED so q never sticks at 0)
//   seed      : new seed value
//   advance   : step the LFSR once
//   q         : current LFSR state
module sort_lfsr
    import sort_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_seed,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= DEFAULT_SEED;
        end else if (load_seed) begin
            q <= (seed == 32'h0) ? DEFAULT_SEED : seed;
        end else if (advance) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/sort_data_loader.sv
// Fill stage for the bubble-sort engine: writes 2^ADDR_W LFSR words to the sort
// memory at addresses 0..2^ADDR_W-1, then pulses sort_start and reports a checksum.
//   clk, rstn     : clock, synchronous active-low reset
//   load          : fill request, honoured only while idle
//   seed_valid    : with load, reseed the LFSR from seed_in
//   seed_in       : new LFSR seed
//   mem           : memory write port (master side)
//   busy          : fill in progress (cycle after accepted load until sort_start)
//   sort_start    : one-cycle pulse when the fill is complete
//   load_done     : sticky completion flag, cleared by the next accepted load
//   checksum      : mod-2^32 sum of the words written in the last fill
//   words_written : writes issued in the current or last fill
module sort_data_loader
    import sort_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       load,
    input  logic                       seed_valid,
    input  logic [31:0]                seed_in,
    sort_data_loader_if.master         mem,
    output logic                       busy,
    output logic                       sort_start,
    output logic                       load_done,
    output logic [31:0]                checksum,
    output logic [ADDR_W:0]            words_written
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              busy_q, busy_d;
    logic              sort_start_q, sort_start_d;
    logic              load_done_q, load_done_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic              load_seed;
    logic              advance;
    logic [31:0]       lfsr_q;

    sort_lfsr u_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .load_seed (load_seed),
        .seed      (seed_in),
        .advance   (advance),
        .q         (lfsr_q)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        busy_d       = busy_q;
        sort_start_d = 1'b0;
        load_done_d  = load_done_q;
        checksum_d   = checksum_q;
        words_d      = words_q;
        load_seed    = 1'b0;
        advance      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    // Without seed_valid the LFSR carries on from the previous fill.
                    load_seed   = seed_valid;
                    busy_d      = 1'b1;
                    load_done_d = 1'b0;
                    state_d     = SEED;
                end
            end
            SEED: begin
                checksum_d = '0;
                words_d    = '0;
                cnt_d      = '0;
                state_d    = FILL;
            end
            FILL: begin
                mem_we_d   = 1'b1;
                mem_addr_d = cnt_q;
                mem_din_d  = lfsr_q;
                checksum_d = checksum_q + lfsr_q;
                words_d    = words_q + 1'b1;
                advance    = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                sort_start_d = 1'b1;
                load_done_d  = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            busy_q       <= 1'b0;
            sort_start_q <= 1'b0;
            load_done_q  <= 1'b0;
            checksum_q   <= '0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            busy_q       <= busy_d;
            sort_start_q <= sort_start_d;
            load_done_q  <= load_done_d;
            checksum_q   <= checksum_d;
            words_q      <= words_d;
        end
    end

    assign mem.we        = mem_we_q;
    assign mem.addr      = mem_addr_q;
    assign mem.din       = mem_din_q;
    assign busy          = busy_q;
    assign sort_start    = sort_start_q;
    assign load_done     = load_done_q;
    assign checksum      = checksum_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_sort_data_loader.sv
// Self-checking bench for sort_data_loader: a timeline model (cycles since the
// accepted load) predicts every output each cycle; directed scenarios add literal checks.
module tb_sort_data_loader;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] TAPS  = 32'h8020_0003;
    localparam logic [31:0] DEF   = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed_in = 32'h0;
    logic        busy, sort_start, load_done;
    logic [31:0] checksum;
    logic [10:0] words_written;

    always #5 clk = ~clk;

    sort_data_loader_if mem_bus ();

    sort_data_loader dut (
        .clk           (clk),
        .rstn          (rstn),
        .load          (load),
        .seed_valid    (seed_valid),
        .seed_in       (seed_in),
        .mem           (mem_bus),
        .busy          (busy),
        .sort_start    (sort_start),
        .load_done     (load_done),
        .checksum      (checksum),
        .words_written (words_written)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] s);
        logic [31:0] sh;
        sh = s >> 1;
        if (s[0]) return sh ^ TAPS;
        return sh;
    endfunction

    // Model: m_k counts edges since the accepted load (-1 when idle).
    logic [31:0] seq [DEPTH];
    logic [31:0] m_lfsr;
    int          m_k;
    bit          m_valid = 1'b0;
    logic        e_we, e_busy, e_ss, e_ld;
    logic [9:0]  e_addr;
    logic [31:0] e_din, e_sum;
    logic [10:0] e_ww;

    logic [31:0] cap [DEPTH];
    int          we_cnt = 0;
    int          ss_cnt = 0;

    task model_step();
        if (!rstn) begin
            m_k    = -1;
            m_lfsr = DEF;
            e_we = 0; e_busy = 0; e_ss = 0; e_ld = 0;
            e_addr = 0; e_din = 0; e_sum = 0; e_ww = 0;
        end else begin
            e_ss = 0;
            if (m_k < 0) begin
                if (load) begin
                    if (seed_valid) m_lfsr = (seed_in == 32'h0) ? DEF : seed_in;
                    for (int i = 0; i < DEPTH; i++) begin
                        seq[i] = m_lfsr;
                        m_lfsr = nxt(m_lfsr);
                    end
                    m_k    = 0;
                    e_busy = 1;
                    e_ld   = 0;
                end
            end else begin
                m_k++;
                if (m_k == 1) begin
                    e_sum = 0;
                    e_ww  = 0;
                end else if (m_k <= DEPTH + 1) begin
                    e_we   = 1;
                    e_addr = 10'(m_k - 2);
                    e_din  = seq[m_k - 2];
                    e_sum  = e_sum + seq[m_k - 2];
                    e_ww   = 11'(m_k - 1);
                end else begin
                    e_we   = 0;
                    e_ss   = 1;
                    e_ld   = 1;
                    e_busy = 0;
                    m_k    = -1;
                end
            end
        end
    endtask

    // Compare process: outputs settled after the previous posedge are checked here,
    // then the model advances using the inputs the next posedge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("mem_we", mem_bus.we, e_we);
                chk("mem_addr", mem_bus.addr, e_addr);
                chk("mem_din", mem_bus.din, e_din);
                chk("busy", busy, e_busy);
                chk("sort_start", sort_start, e_ss);
                chk("load_done", load_done, e_ld);
                chk("checksum", checksum, e_sum);
                chk("words_written", words_written, e_ww);
                if (mem_bus.we === 1'b1) begin
                    cap[mem_bus.addr] = mem_bus.din;
                    we_cnt++;
                end
                if (sort_start === 1'b1) ss_cnt++;
            end
            model_step();
            m_valid = 1'b1;
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task pulse_load(input bit sv, input logic [31:0] s);
        load       = 1'b1;
        seed_valid = sv;
        seed_in    = s;
        tick();
        load       = 1'b0;
        seed_valid = 1'b0;
    endtask

    // Latency counted in edges from the load edge (inclusive) to sort_start.
    task wait_start(output int lat);
        lat = 1;
        while (sort_start !== 1'b1 && lat < 1100) begin
            tick();
            lat++;
        end
    endtask

    task chk_default_head(input string tag);
        chk({tag, "_addr0"}, cap[0], 32'h0000_0001);
        chk({tag, "_addr1"}, cap[1], 32'h8020_0003);
        chk({tag, "_addr2"}, cap[2], 32'hC030_0002);
        chk({tag, "_addr3"}, cap[3], 32'h6018_0001);
    endtask

    initial begin
        int          lat;
        logic [31:0] sum_default;
        logic [31:0] prev_last;

        repeat (3) tick();
        chk("rst_mem_we", mem_bus.we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_checksum", checksum, 32'h0);
        chk("rst_words", words_written, 11'd0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_sort_start", sort_start, 1'b0);
        rstn = 1'b1;
        tick();

        // Default-seed fill run to completion.
        we_cnt = 0;
        ss_cnt = 0;
        pulse_load(1'b0, $urandom);
        wait_start(lat);
        chk("a_latency", lat, 1027);
        tick();
        chk("a_we_cycles", we_cnt, 1024);
        chk("a_ss_pulses", ss_cnt, 1);
        chk("a_ss_low", sort_start, 1'b0);
        chk("a_words", words_written, 11'd1024);
        chk("a_load_done", load_done, 1'b1);
        chk_default_head("a");
        sum_default = e_sum;
        prev_last   = cap[DEPTH-1];

        // Zero seed falls back to DEFAULT_SEED: same data and checksum.
        pulse_load(1'b1, 32'h0);
        wait_start(lat);
        chk("b_latency", lat, 1027);
        chk("b_checksum", checksum, sum_default);
        chk("b_last", cap[DEPTH-1], prev_last);
        chk_default_head("b");
        prev_last = cap[DEPTH-1];

        // Back-to-back load on the sort_start cycle continues the sequence.
        pulse_load(1'b0, 32'h0);
        chk("c_load_done_low", load_done, 1'b0);
        chk("c_busy", busy, 1'b1);
        wait_start(lat);
        chk("c_latency", lat, 1027);
        chk("c_load_done_high", load_done, 1'b1);
        chk("c_addr0", cap[0], nxt(prev_last));

        // seed_valid alone is ignored; loads mid-fill and in HANDOFF are dropped.
        tick();
        seed_valid = 1'b1;
        seed_in    = $urandom;
        repeat (5) tick();
        seed_valid = 1'b0;
        we_cnt = 0;
        ss_cnt = 0;
        pulse_load(1'b1, 32'hDEAD_BEEF);
        repeat (4) tick();
        pulse_load(1'b1, $urandom);
        repeat (1020) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("d_sort_start", sort_start, 1'b1);
        repeat (3) tick();
        chk("d_we_cycles", we_cnt, 1024);
        chk("d_ss_pulses", ss_cnt, 1);
        chk("d_busy", busy, 1'b0);
        chk("d_addr0", cap[0], 32'hDEAD_BEEF);
        chk("d_addr1", cap[1], 32'hEF76_DF74);

        // Reset in the middle of a fill.
        pulse_load(1'b0, 32'h0);
        repeat (300) tick();
        rstn = 1'b0;
        tick();
        chk("e_mem_we", mem_bus.we, 1'b0);
        chk("e_busy", busy, 1'b0);
        chk("e_checksum", checksum, 32'h0);
        chk("e_words", words_written, 11'd0);
        rstn = 1'b1;
        tick();
        pulse_load(1'b0, $urandom);
        wait_start(lat);
        chk("e_latency", lat, 1027);
        chk_default_head("e");

        // Randomised traffic against the model.
        repeat (6000) begin
            load       = ($urandom_range(0, 299) == 0);
            seed_valid = $urandom_range(0, 1) == 1;
            seed_in    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rstn       = ($urandom_range(0, 2999) != 0);
            tick();
        end
        load       = 1'b0;
        seed_valid = 1'b0;
        rstn       = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
